// File: rtl/ps2_pkg.sv
// ps2_pkg: shared types and constants for the PS/2 host transmit path.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ps2_pkg;

    // Host transmitter states
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        INHIBIT  = 3'd1,
        WAIT_DEV = 3'd2,
        SEND     = 3'd3,
        ACK      = 3'd4,
        WAIT_REL = 3'd5,
        DONE     = 3'd6,
        ERR      = 3'd7
    } tx_state_t;

    // Common keyboard commands and responses
    localparam logic [7:0] CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] CMD_RESET    = 8'hFF;
    localparam logic [7:0] RSP_ACK      = 8'hFA;
    localparam logic [7:0] RSP_RESEND   = 8'hFE;

    // Extra attempts after a NACK or transfer timeout when retry is built in
    localparam int MAX_RETRY = 2;

    // Odd parity: data plus parity bit carries an odd number of ones
    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// ps2_line_sync: 2-flop synchronizers for ps2clk/ps2data plus a falling-edge strobe on the clock.
// Latency: 2 cycles to sync_clk/sync_data, fall fires 2-3 cycles after the raw line drops.
// Backpressure: none; free-running sampler.
module ps2_line_sync (
    input  logic clk,
    input  logic reset,
    input  logic ps2clk_in,
    input  logic ps2data_in,
    output logic sync_clk,
    output logic sync_data,
    output logic fall
);

    logic [1:0] clk_ff;
    logic [1:0] data_ff;
    logic       sync_clk_d;

    // Synchronizer chains; idle lines are pulled up so reset to 1
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clk_ff     <= 2'b11;
            data_ff    <= 2'b11;
            sync_clk_d <= 1'b1;
        end else begin
            clk_ff     <= {clk_ff[0], ps2clk_in};
            data_ff    <= {data_ff[0], ps2data_in};
            sync_clk_d <= clk_ff[1];
        end
    end

    assign sync_clk  = clk_ff[1];
    assign sync_data = data_ff[1];
    assign fall      = sync_clk_d & ~sync_clk;

endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 command transmitter (inhibit, start, 8 data LSB first, odd parity, stop, ACK).
// Latency: INHIBIT_CYC+1 cycles of inhibit, then paced by the device clock; done/error one cycle after resolution.
// Backpressure: tx_ready low for the whole transfer; tx_valid while busy is dropped, nothing is queued.
// Build option PS2_TX_RETRY_EN: resend on NACK or transfer timeout, up to 2 retries; start timeout never retried.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYC  = 2500,
    parameter int START_TO_CYC = 375000,
    parameter int XFER_TO_CYC  = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_error,
    input  logic       ps2clk_in,
    input  logic       ps2data_in,
    output logic       ps2clk_oe,
    output logic       ps2data_oe
);

    // One timer serves inhibit, start timeout and transfer timeout; size it for the largest
    localparam int TMAX = (START_TO_CYC > XFER_TO_CYC)
                        ? ((START_TO_CYC > INHIBIT_CYC) ? START_TO_CYC : INHIBIT_CYC)
                        : ((XFER_TO_CYC > INHIBIT_CYC) ? XFER_TO_CYC : INHIBIT_CYC);
    localparam int TW = $clog2(TMAX + 1);

    localparam logic [TW-1:0] INH_LAST   = TW'(INHIBIT_CYC);
    localparam logic [TW-1:0] START_LAST = TW'(START_TO_CYC - 1);
    localparam logic [TW-1:0] XFER_LAST  = TW'(XFER_TO_CYC - 1);

    logic          sync_clk;
    logic          sync_data;
    logic          fall;

    tx_state_t     state;
    tx_state_t     state_nxt;
    tx_state_t     fail_st;
    logic [TW-1:0] timer;
    logic          timer_clr;
    logic [3:0]    bitcnt;
    logic [3:0]    bit_idx;
    logic [8:0]    frame;      // {parity, data}; kept intact so a retry can resend it
    logic          retry_ok;
    logic          inh_end;
    logic          start_to;
    logic          xfer_to;

    ps2_line_sync u_sync (
        .clk        (clk),
        .reset      (reset),
        .ps2clk_in  (ps2clk_in),
        .ps2data_in (ps2data_in),
        .sync_clk   (sync_clk),
        .sync_data  (sync_data),
        .fall       (fall)
    );

    assign inh_end  = (timer == INH_LAST);
    assign start_to = (timer == START_LAST);
    assign xfer_to  = (timer == XFER_LAST);
    assign bit_idx  = bitcnt - 4'd1;

`ifdef PS2_TX_RETRY_EN
    logic [1:0] tries;

    assign retry_ok = (tries != 2'(MAX_RETRY));

    // Count resends of the current byte; a fresh request starts over
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tries <= 2'd0;
        end else if (state == IDLE && tx_valid) begin
            tries <= 2'd0;
        end else if (state_nxt == INHIBIT && (state inside {SEND, ACK, WAIT_REL})) begin
            tries <= tries + 2'd1;
        end
    end
`else
    assign retry_ok = 1'b0;
`endif

    // Where a NACK or transfer timeout leads: another attempt, or give up
    assign fail_st = retry_ok ? INHIBIT : ERR;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; transfer timeout outranks bit/ack events
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (tx_valid) state_nxt = INHIBIT;
            INHIBIT:  if (inh_end) state_nxt = WAIT_DEV;
            WAIT_DEV: begin
                if (fall)          state_nxt = SEND;
                else if (start_to) state_nxt = ERR;
            end
            SEND: begin
                if (xfer_to)                     state_nxt = fail_st;
                else if (fall && bitcnt == 4'd10) state_nxt = ACK;
            end
            ACK: begin
                if (xfer_to)        state_nxt = fail_st;
                else if (sync_data) state_nxt = fail_st;
                else                state_nxt = WAIT_REL;
            end
            WAIT_REL: begin
                if (xfer_to)                    state_nxt = fail_st;
                else if (sync_clk && sync_data) state_nxt = DONE;
            end
            DONE:     state_nxt = IDLE;
            ERR:      state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // Timer restarts on entry to INHIBIT, WAIT_DEV and SEND; runs on through ACK and WAIT_REL
    assign timer_clr = (state_nxt != state) && (state_nxt inside {INHIBIT, WAIT_DEV, SEND});

    // Timer, bit counter and frame capture
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            timer  <= '0;
            bitcnt <= 4'd0;
            frame  <= 9'd0;
        end else begin
            if (timer_clr || (state inside {IDLE, DONE, ERR})) begin
                timer <= '0;
            end else begin
                timer <= timer + TW'(1);
            end

            if (state == IDLE && tx_valid) begin
                frame  <= {odd_parity(tx_data), tx_data};
                bitcnt <= 4'd0;
            end else if (state == WAIT_DEV && fall) begin
                bitcnt <= 4'd1;
            end else if (state == SEND && fall) begin
                bitcnt <= bitcnt + 4'd1;
            end
        end
    end

    // Outputs decoded from state; bitcnt n in SEND means frame bit n-1 is on the wire
    always_comb begin
        tx_ready   = 1'b0;
        busy       = 1'b1;
        tx_done    = 1'b0;
        tx_error   = 1'b0;
        ps2clk_oe  = 1'b0;
        ps2data_oe = 1'b0;
        case (state)
            IDLE: begin
                tx_ready = 1'b1;
                busy     = 1'b0;
            end
            INHIBIT: begin
                ps2clk_oe  = 1'b1;
                ps2data_oe = inh_end;
            end
            WAIT_DEV: ps2data_oe = 1'b1;
            SEND: begin
                if (bitcnt >= 4'd1 && bitcnt <= 4'd9) begin
                    ps2data_oe = ~frame[bit_idx];
                end
            end
            DONE:    tx_done  = 1'b1;
            ERR:     tx_error = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter: sends one command byte (e.g. 0xED set-LEDs, 0xFF reset) from the FPGA to the keyboard. It is the opposite direction of the existing PS/2 receive path.
- Runs on the 25 MHz pixel clock (clk25 at top level).
- Drives ps2clk/ps2data through open-drain enables. Top level builds tristates: line = oe ? 0 : Z.
- Asserts busy so the top level can gate the receiver's found/scancode during a transmission.

Parameters:
- INHIBIT_CYC, 2500: cycles the host holds ps2clk low before the start bit (100 us at 25 MHz).
- START_TO_CYC, 375000: max cycles from clock release to the first device falling edge (15 ms).
- XFER_TO_CYC, 50000: max cycles from the first falling edge to the ACK edge (2 ms).

Ports:
- clk  in  1  system clock (25 MHz)
- reset  in  1  asynchronous, active-low reset
- tx_data  in  8  command byte
- tx_valid  in  1  request; sampled only while tx_ready=1
- tx_ready  out  1  idle, can accept a byte
- busy  out  1  transfer in progress (any state other than IDLE)
- tx_done  out  1  one-cycle pulse: byte sent and ACK seen
- tx_error  out  1  one-cycle pulse: timeout or NACK
- ps2clk_in  in  1  raw ps2clk line (asynchronous)
- ps2data_in  in  1  raw ps2data line (asynchronous)
- ps2clk_oe  out  1  1 = pull ps2clk low
- ps2data_oe  out  1  1 = pull ps2data low

Behaviour:
- Reset (reset=0, async):
  - state=IDLE, tx_ready=1, busy=0, tx_done=0, tx_error=0, ps2clk_oe=0, ps2data_oe=0, counters=0.
  - A reset mid-transfer releases both lines immediately.
- Input sync: ps2clk_in and ps2data_in pass through 2-flop synchronizers. fall = sync_clk_d & ~sync_clk. All edge decisions use the synchronized signals (2-3 cycle latency, acceptable).
- IDLE:
  - tx_valid & tx_ready: latch tx_data into shreg.
  - Compute parity = ~^tx_data (odd parity over data plus parity bit).
  - Clear counters and go to INHIBIT. tx_ready drops the next cycle.
- INHIBIT:
  - ps2clk_oe=1.
  - After INHIBIT_CYC cycles: set ps2data_oe=1 (start bit = 0) and hold ps2clk_oe=1 for exactly one more cycle.
  - Then ps2clk_oe=0 and go to WAIT_DEV with the timeout counter cleared.
- WAIT_DEV:
  - Data is held low.
  - First fall: drive bit0 (ps2data_oe = ~shreg[0]), bitcnt=1, go to SEND.
  - Counter reaches START_TO_CYC: go to ERR.
- SEND (the value is changed on each fall; the device samples on the rising edge):
  - fall with bitcnt 1..7: drive data bit bitcnt.
  - fall with bitcnt=8: drive parity.
  - fall with bitcnt=9: ps2data_oe=0 (stop bit = 1).
  - fall with bitcnt=10: go to ACK check.
  - bitcnt increments on each fall.
- ACK: sample sync_data at the 11th fall.
  - Low: go to WAIT_REL.
  - High: go to ERR (NACK).
- WAIT_REL: wait until sync_clk=1 and sync_data=1, then go to DONE.
- DONE: one-cycle tx_done pulse, then IDLE.
- ERR: one-cycle tx_error pulse with both oe released, then IDLE.
- Transfer timeout: the XFER_TO_CYC counter runs from entry to SEND until leaving WAIT_REL. On expiry, go to ERR from any of those states.
- Ordering rules:
  - tx_valid outside IDLE is ignored; no queue.
  - tx_done and tx_error never assert in the same cycle.
- Line levels: ps2clk_oe is only ever asserted in INHIBIT. The host never drives a line high.

Optional Feature:
- Macro: PS2_TX_RETRY_EN.
- Defined:
  - On NACK or transfer timeout, the byte is resent automatically from INHIBIT, up to 2 retries (3 attempts total).
  - tx_error pulses only after the final failure.
  - A start timeout (device absent) is not retried.
- Undefined: any failure pulses tx_error immediately and returns to IDLE.

Decomposition:
- Package ps2_pkg:
  - tx state enum (IDLE, INHIBIT, WAIT_DEV, SEND, ACK, WAIT_REL, DONE, ERR).
  - Command constants: CMD_SET_LEDS=8'hED, CMD_RESET=8'hFF, RSP_ACK=8'hFA, RSP_RESEND=8'hFE.
- Sub-module ps2_line_sync: 2-flop synchronizers for clk and data plus the falling-edge strobe. It is shareable with the receive path.

Test Plan:
- tx_data=8'hED, BFM device clocks at 12.5 kHz and ACKs:
  - ps2clk_oe low for 2500 cycles.
  - Device captures start=0, bits 1,0,1,1,0,1,1,1 (LSB first), parity=1, stop=1.
  - One tx_done pulse, busy back to 0.
- tx_data=8'h00: captured parity=1. tx_data=8'h01: parity=0. Both complete with tx_done.
- Device never clocks: tx_error exactly 375000 cycles after clock release, both oe=0, tx_ready=1.
- Device holds data high on the 11th edge (NACK):
  - Without PS2_TX_RETRY_EN: one tx_error.
  - With PS2_TX_RETRY_EN: 3 inhibit phases, then a single tx_error.
- reset=0 asserted during SEND bit 4: both oe=0 in the same cycle, tx_ready=1, no done/error pulse. A later tx_valid of 8'hFF completes normally.
- tx_valid pulsed with 8'h55 while busy: ignored, and the in-flight byte 8'hED is transmitted unchanged.
